// File: rtl/vfifo_axis_packer.sv
// rtl/vfifo_axis_packer.sv - FIFO-style write port to AXI4-Stream packer for the DDR3 virtual FIFO
// Ports:
//   BUS_CLK, BUS_RST_N          single clock, asynchronous active-low reset
//   DATA_IN, WRITE, FULL        FIFO-style write port (WRITE ignored while FULL)
//   EMPTY                       nothing buffered and no beat on the stream
//   FLUSH                       one-cycle pulse closing the current partial packet
//   m_axis_tvalid/tready/tdata/tlast/tdest  registered AXI4-Stream master
// Optional: define VFIFO_AXIS_PACKER_STATS_EN to add STAT_CLR plus the
//   stat_packets / stat_timeouts / stat_drops saturating counters.
module vfifo_axis_packer #(
    parameter int BURST_WORDS   = 128,
    parameter int DEPTH_LOG2    = 3,
    parameter int TIMEOUT       = 1024,
    parameter int SWAP_CHANNELS = 0
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST_N,
    input  logic [31:0] DATA_IN,
    input  logic        WRITE,
    output logic        FULL,
    output logic        EMPTY,
    input  logic        FLUSH,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tdest
`ifdef VFIFO_AXIS_PACKER_STATS_EN
    ,
    input  logic        STAT_CLR,
    output logic [31:0] stat_packets,
    output logic [15:0] stat_timeouts,
    output logic [15:0] stat_drops
`endif
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int WCW   = $clog2(BURST_WORDS);
    localparam int IW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_TWO  = CW'(2);
    localparam logic [WCW-1:0] WC_LAST  = WCW'(BURST_WORDS - 1);
    localparam logic [IW-1:0]  IDLE_MAX = IW'(TIMEOUT);

    logic [31:0]    mem [DEPTH];
    logic [CW-1:0]  wr_ptr;
    logic [CW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_cnt;
    logic [WCW-1:0] word_cnt;
    logic [IW-1:0]  idle_cnt;
    logic           flush_pend;
    logic           push;
    logic           burst_end;
    logic           timeout_hit;
    logic           hold_close;
    logic           rel_ok;
    logic           load;
    logic           load_last;

    // Pointers carry one extra MSB so a full FIFO differs from an empty one.
    assign fifo_cnt    = wr_ptr - rd_ptr;
    assign FULL        = (fifo_cnt == CNT_FULL);
    assign EMPTY       = (fifo_cnt == '0) && !m_axis_tvalid;
    assign push        = WRITE && !FULL;
    assign burst_end   = (word_cnt == WC_LAST);
    assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == IDLE_MAX);

    // The last buffered word is held back until we know whether it ends a
    // packet: another word arriving, the burst boundary, idle timeout or flush.
    assign hold_close  = (fifo_cnt == CNT_ONE) && (timeout_hit || flush_pend);
    assign rel_ok      = (fifo_cnt >= CNT_TWO) ||
                         ((fifo_cnt == CNT_ONE) && burst_end) || hold_close;
    assign load        = (!m_axis_tvalid || m_axis_tready) && rel_ok;
    assign load_last   = burst_end || hold_close;

    always_ff @(posedge BUS_CLK) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= DATA_IN;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            word_cnt      <= '0;
            idle_cnt      <= '0;
            flush_pend    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdest  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CW'(1);
            end

            if (load) begin
                rd_ptr        <= rd_ptr + CW'(1);
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                m_axis_tlast  <= load_last;
                word_cnt      <= load_last ? '0 : word_cnt + WCW'(1);
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end

            if (push || (fifo_cnt == '0)) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IW'(1);
            end

            // Closing wins over a coincident FLUSH so a pending flush never
            // outlives the packet it was meant to close.
            if (load && load_last) begin
                flush_pend <= 1'b0;
            end else if (FLUSH && (fifo_cnt != '0)) begin
                flush_pend <= 1'b1;
            end

            if ((SWAP_CHANNELS != 0) && m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                m_axis_tdest <= ~m_axis_tdest;
            end
        end
    end

`ifdef VFIFO_AXIS_PACKER_STATS_EN
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            stat_packets  <= '0;
            stat_timeouts <= '0;
            stat_drops    <= '0;
        end else if (STAT_CLR) begin
            stat_packets  <= '0;
            stat_timeouts <= '0;
            stat_drops    <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast && (stat_packets != '1)) begin
                stat_packets <= stat_packets + 32'd1;
            end
            if (load && !burst_end && hold_close && timeout_hit && (stat_timeouts != '1)) begin
                stat_timeouts <= stat_timeouts + 16'd1;
            end
            if (WRITE && FULL && (stat_drops != '1)) begin
                stat_drops <= stat_drops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vfifo_axis_packer.sv
// tb/tb_vfifo_axis_packer.sv - scoreboard bench for vfifo_axis_packer
module tb_vfifo_axis_packer;
    localparam int BW = 128;
    localparam int DL = 3;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = '0;
    logic        write = 1'b0;
    logic        flush = 1'b0;
    logic        tready = 1'b0;
    logic        full;
    logic        empty;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        tdest;
`ifdef VFIFO_AXIS_PACKER_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_packets;
    logic [15:0] stat_timeouts;
    logic [15:0] stat_drops;
`endif

    always #5 clk = ~clk;

    vfifo_axis_packer #(
        .BURST_WORDS(BW), .DEPTH_LOG2(DL), .TIMEOUT(TO), .SWAP_CHANNELS(1)
    ) dut (
        .BUS_CLK(clk), .BUS_RST_N(rst_n), .DATA_IN(din), .WRITE(write),
        .FULL(full), .EMPTY(empty), .FLUSH(flush),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
        .m_axis_tlast(tlast), .m_axis_tdest(tdest)
`ifdef VFIFO_AXIS_PACKER_STATS_EN
        , .STAT_CLR(stat_clr), .stat_packets(stat_packets),
        .stat_timeouts(stat_timeouts), .stat_drops(stat_drops)
`endif
    );

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        t;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beats = 0;
    int    pos = 0;      // word index inside the current model packet
    int    pkt = 0;      // packets closed since reset
    int    rdy_mode = 0; // 0: ready high, 1: random, 2: ready low
    int    stall_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: tready = 1'b1;
            2: tready = 1'b0;
            default: begin
                if (stall_run >= 3 || $urandom_range(3) != 0) begin
                    tready = 1'b1;
                    stall_run = 0;
                end else begin
                    tready = 1'b0;
                    stall_run++;
                end
            end
        endcase
    endtask

    // Model: packets are BW words long unless the stream goes quiet or is
    // flushed, in which case the last word written closes the packet.
    task automatic push_exp(input logic [31:0] d);
        beat_t b;
        b.d = d;
        b.l = (pos == BW - 1);
        b.t = pkt[0];
        exp_q.push_back(b);
        if (pos == BW - 1) begin
            pos = 0;
            pkt++;
        end else begin
            pos++;
        end
    endtask

    task automatic close_phase();
        beat_t b;
        if (exp_q.size() > 0) begin
            b = exp_q.pop_back();
            if (!b.l) begin
                b.l = 1'b1;
                pos = 0;
                pkt++;
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic write_word(input logic [31:0] d);
        int w = 0;
        while (full && w < 200) begin
            step();
            w++;
        end
        if (w >= 200) check("full_wait_timeout", 32'(w), 32'd0);
        write = 1'b1;
        din = d;
        push_exp(d);
        step();
        write = 1'b0;
    endtask

    task automatic idle_drain(input string name);
        rdy_mode = 0;
        repeat (TO + 40) step();
        check({name, "_empty"}, {31'd0, empty}, 32'd1);
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: samples mid-cycle, checks AXI stability under backpressure and
    // pops the scoreboard on each handshake.
    beat_t held;
    logic  held_pend = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            held_pend = 1'b0;
        end else begin
            if (held_pend) begin
                check("stable_tvalid", {31'd0, tvalid}, 32'd1);
                check("stable_tdata", tdata, held.d);
                check("stable_tlast_tdest", {30'd0, tlast, tdest}, {30'd0, held.l, held.t});
            end
            if (tvalid && tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", tdata, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_tdata", tdata, e.d);
                    check("beat_tlast", {31'd0, tlast}, {31'd0, e.l});
                    check("beat_tdest", {31'd0, tdest}, {31'd0, e.t});
                end
            end
            held_pend = tvalid && !tready;
            held.d = tdata;
            held.l = tlast;
            held.t = tdest;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b0;
        logic [31:0] d;

        // Reset values
        #1;
        check("rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("rst_tlast_tdest", {30'd0, tlast, tdest}, 32'd0);
        check("rst_tdata", tdata, 32'd0);
        check("rst_full_empty", {30'd0, full, empty}, 32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Two back-to-back bursts, ready always high
        rdy_mode = 0;
        for (int i = 0; i < 256; i++) write_word(32'(i));
        close_phase();
        idle_drain("burst256");

        // Idle timeout closes a 5-word partial packet 17 cycles after last write
        for (int i = 0; i < 5; i++) write_word(32'h100 + 32'(i));
        close_phase();
        n = 0;
        while (!(tvalid && tlast) && n < 60) begin
            step();
            n++;
        end
        check("timeout_latency", 32'(n), 32'd17);
        idle_drain("timeout");

        // FLUSH closes a 3-word packet well before the timeout
        for (int i = 0; i < 3; i++) write_word(32'h200 + 32'(i));
        close_phase();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n = 0;
        while (!(tvalid && tlast) && n < 60) begin
            step();
            n++;
        end
        check("flush_latency_short", {31'd0, (n <= 3)}, 32'd1);
        idle_drain("flush");

        // FLUSH on an empty FIFO yields no beat
        b0 = beats;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (10) step();
        check("empty_flush_no_beat", 32'(beats - b0), 32'd0);
        check("empty_flush_empty", {31'd0, empty}, 32'd1);

        // Backpressure: 12 writes with ready low, 9 fit (8 FIFO + output reg)
        rdy_mode = 2;
        step();
        for (int i = 0; i < 12; i++) begin
            check("full_flag", {31'd0, full}, {31'd0, (i >= 9)});
            write = 1'b1;
            din = 32'h300 + 32'(i);
            if (i < 9) push_exp(din);
            step();
        end
        write = 1'b0;
        check("full_after", {31'd0, full}, 32'd1);
        check("full_head_data", tdata, 32'h300);
`ifdef VFIFO_AXIS_PACKER_STATS_EN
        check("stat_drops", {16'd0, stat_drops}, 32'd3);
`endif
        repeat (5) step();
        close_phase();
        idle_drain("full_drain");

        // Asynchronous reset in the middle of a packet
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) write_word(32'h400 + 32'(i));
        check("pre_reset_tvalid", {31'd0, tvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_tvalid", {31'd0, tvalid}, 32'd0);
        check("async_rst_empty", {31'd0, empty}, 32'd1);
        exp_q.delete();
        pos = 0;
        pkt = 0;
        step();
        step();
        rst_n = 1'b1;
        rdy_mode = 0;
        step();
        for (int i = 0; i < 128; i++) write_word(32'h500 + 32'(i));
        close_phase();
        idle_drain("post_reset");

        // Randomised phases: random data, gaps and backpressure
        for (int p = 0; p < 10; p++) begin
            int len;
            bit use_flush;
            len = $urandom_range(300, 1);
            use_flush = 1'($urandom_range(1));
            rdy_mode = 1;
            for (int i = 0; i < len; i++) begin
                d = $urandom;
                write_word(d);
                repeat ($urandom_range(2)) step();
            end
            close_phase();
            if (use_flush) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
            end
            idle_drain("random_phase");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
